pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It watches the ID and EX stages and the data-memory handshake, and drives the write-enable, flush and hold lines of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: load-use stalls, branch/jump redirects, multi-cycle mult/div occupancy and data-memory wait states. It is the single owner of every stall and flush decision in the core.

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirects, mult/div
// occupancy and data-memory wait states, with a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ID_RS,
  input  logic [4:0] ID_RT,
  input  logic       ID_UsesRS,
  input  logic       ID_UsesRT,
  input  logic       ID_MulDiv,
  input  logic       EX_MEM_RDEN,
  input  logic [4:0] EX_RT,
  input  logic [1:0] EX_PCSrc,
  input  logic       MEM_Req,
  input  logic       MEM_Ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       Pipe_Hold,
  output logic       MulDiv_Busy,
  output logic       MemFault
);

  typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, MEMWAIT = 2'd2} state_t;

  localparam logic [4:0]  MD_LOAD = 5'(MULDIV_CYCLES - 1);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] wait_q, wait_d;
  logic        fault_q, fault_d;

  logic lu, ms, run_eval;
  logic pc_w, ifid_w, ifid_fl, idex_fl, hold, busy;

  assign lu = EX_MEM_RDEN && (EX_RT != 5'd0) &&
              ((ID_UsesRS && (ID_RS == EX_RT)) || (ID_UsesRT && (ID_RT == EX_RT)));
  assign ms = MEM_Req && !MEM_Ready;

  always_comb begin
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    hold     = 1'b0;
    busy     = 1'b0;
    run_eval = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;

    case (state_q)
      RUN: begin
        if (ms) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          hold    = 1'b1;
          wait_d  = 16'd1;
          state_d = MEMWAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!MEM_Ready) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          hold   = 1'b1;
          if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
        end else begin
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      MULDIV: begin
        busy   = 1'b1;
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        // A memory stall freezes the whole pipe, so the bubble count must not advance.
        if (ms) begin
          hold = 1'b1;
        end else begin
          idex_fl = 1'b1;
          if (cnt_q == 5'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      if (EX_PCSrc != 2'b00) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end else if (lu) begin
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        idex_fl = 1'b1;
      end else if (ID_MulDiv) begin
        cnt_d   = MD_LOAD;
        state_d = MULDIV;
      end
    end

    fault_d = fault_q | (wait_d >= TIMEOUT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 5'd0;
      wait_q  <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign PC_Write    = pc_w    & ~reset;
  assign IF_ID_Write = ifid_w  & ~reset;
  assign IF_ID_Flush = ifid_fl & ~reset;
  assign ID_EX_Flush = idex_fl & ~reset;
  assign Pipe_Hold   = hold    & ~reset;
  assign MulDiv_Busy = busy    & ~reset;
  assign MemFault    = fault_q & ~reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MULDIV_CYCLES=4, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ID_RS, ID_RT, EX_RT;
  logic       ID_UsesRS, ID_UsesRT, ID_MulDiv, EX_MEM_RDEN;
  logic [1:0] EX_PCSrc;
  logic       MEM_Req, MEM_Ready;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MulDiv_Busy, MemFault;

  int tests = 0;
  int fails = 0;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MulDiv_Busy, MemFault}
  logic [6:0] outs;
  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MulDiv_Busy, MemFault};

  localparam logic [6:0] ZERO  = 7'b0000000;
  localparam logic [6:0] DEF   = 7'b1100000;
  localparam logic [6:0] LUS   = 7'b0001000;
  localparam logic [6:0] REDIR = 7'b1111000;
  localparam logic [6:0] MD    = 7'b0001010;
  localparam logic [6:0] HOLD  = 7'b0000100;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
    .ID_MulDiv(ID_MulDiv), .EX_MEM_RDEN(EX_MEM_RDEN), .EX_RT(EX_RT), .EX_PCSrc(EX_PCSrc),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .Pipe_Hold(Pipe_Hold), .MulDiv_Busy(MulDiv_Busy),
    .MemFault(MemFault)
  );

  always #5 clock = ~clock;

  task automatic idle();
    ID_RS = 5'd0; ID_RT = 5'd0; EX_RT = 5'd0;
    ID_UsesRS = 1'b0; ID_UsesRT = 1'b0; ID_MulDiv = 1'b0;
    EX_MEM_RDEN = 1'b0; EX_PCSrc = 2'b00; MEM_Req = 1'b0; MEM_Ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] mask, input logic [6:0] exp);
    #1;
    tests++;
    assert ((outs & mask) === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, outs & mask, exp);
    end
  endtask

  task automatic lu_inputs(input logic [4:0] rt);
    EX_MEM_RDEN = 1'b1; EX_RT = rt; ID_RS = rt; ID_UsesRS = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    ID_MulDiv = 1'b1;
    tick(); tick();
    chk("reset_gated", 7'h7F, ZERO);
    idle();
    reset = 1'b0;
    chk("post_reset_default", 7'h7F, DEF);

    // load-use on RS
    tick(); lu_inputs(5'd5);
    chk("lu_rs_stall", 7'h7F, LUS);
    tick(); idle();
    chk("lu_release", 7'h7F, DEF);
    tick(); lu_inputs(5'd0);
    chk("lu_r0_nostall", 7'h7F, DEF);
    // load-use on RT, and the same match with UsesRT cleared
    tick(); idle(); EX_MEM_RDEN = 1'b1; EX_RT = 5'd7; ID_RT = 5'd7; ID_UsesRT = 1'b1;
    chk("lu_rt_stall", 7'h7F, LUS);
    tick(); ID_UsesRT = 1'b0;
    chk("lu_rt_unused", 7'h7F, DEF);

    // redirect beats load-use and mult/div
    tick(); idle(); lu_inputs(5'd9); EX_PCSrc = 2'b01;
    chk("redir_over_lu", 7'h7F, REDIR);
    tick(); idle(); EX_PCSrc = 2'b10; ID_MulDiv = 1'b1;
    chk("redir_over_md", 7'h7F, REDIR);
    tick(); idle();
    chk("redir_no_md", 7'h7F, DEF);

    // mult/div: 4 bubble cycles
    tick(); ID_MulDiv = 1'b1;
    chk("md_issue", 7'h7F, DEF);
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      chk($sformatf("md_busy%0d", i), 7'h7F, MD);
    end
    tick();
    chk("md_done", 7'h7F, DEF);

    // memory wait 3 cycles then ready
    tick(); MEM_Req = 1'b1;
    chk("mw_hold0", 7'h7F, HOLD);
    tick(); chk("mw_hold1", 7'h7F, HOLD);
    tick(); chk("mw_hold2", 7'h7F, HOLD);
    tick(); MEM_Ready = 1'b1;
    chk("mw_ready", 7'h7F, DEF);
    tick(); idle();
    chk("mw_after", 7'h7F, DEF);

    // ready cycle re-evaluates load-use
    tick(); MEM_Req = 1'b1;
    chk("mw_lu_hold", 7'h7F, HOLD);
    tick(); MEM_Ready = 1'b1; lu_inputs(5'd3);
    chk("mw_ready_lu", 7'h7F, LUS);
    tick(); idle();
    chk("mw_lu_after", 7'h7F, DEF);

    // hold overrides redirect; redirect applies on release
    tick(); MEM_Req = 1'b1; EX_PCSrc = 2'b01;
    chk("ms_over_redir", 7'h7F, HOLD);
    tick(); MEM_Ready = 1'b1;
    chk("redir_on_release", 7'h7F, REDIR);
    tick(); idle();
    chk("redir_release_after", 7'h7F, DEF);

    // memory stall inside mult/div freezes the bubble count
    tick(); ID_MulDiv = 1'b1;
    chk("md2_issue", 7'h7F, DEF);
    tick(); idle();
    chk("md2_busy0", 7'h7F, MD);
    tick(); MEM_Req = 1'b1;
    chk("md2_ms_hold", 7'b1111101, HOLD);
    for (int i = 1; i < 4; i++) begin
      tick(); idle();
      chk($sformatf("md2_busy%0d", i), 7'h7F, MD);
    end
    tick();
    chk("md2_done", 7'h7F, DEF);

    // timeout: fault visible once 8 wait cycles have elapsed
    for (int i = 1; i <= 10; i++) begin
      tick(); idle(); MEM_Req = 1'b1;
      chk($sformatf("to_wait%0d", i), 7'h7F, (i <= 8) ? HOLD : (HOLD | 7'b0000001));
    end
    tick(); MEM_Ready = 1'b1;
    chk("to_ready_sticky", 7'h7F, DEF | 7'b0000001);
    tick(); idle();
    chk("to_idle_sticky", 7'h7F, DEF | 7'b0000001);
    reset = 1'b1;
    chk("to_reset_zero", 7'h7F, ZERO);
    tick(); reset = 1'b0;
    chk("to_fault_cleared", 7'h7F, DEF);

    // reset on the 2nd mult/div cycle aborts at once
    tick(); ID_MulDiv = 1'b1;
    chk("md3_issue", 7'h7F, DEF);
    tick(); idle();
    chk("md3_busy0", 7'h7F, MD);
    tick();
    chk("md3_busy1", 7'h7F, MD);
    reset = 1'b1;
    chk("md3_reset_zero", 7'h7F, ZERO);
    tick(); reset = 1'b0;
    chk("md3_post_reset", 7'h7F, DEF);
    tick();
    chk("md3_no_residual", 7'h7F, DEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
